// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time program loader for the single-cycle CPU core.
//                Accepts a byte stream made of a 4-byte little-endian word
//                count N followed by 4*N payload bytes. Each group of 4 bytes
//                is written as one little-endian word into instruction memory.
//                The core is held in reset while loading and released once
//                the final word has been written. A reload pulse restarts the
//                load without a global reset.
//
//  Optional feature (compile-time macro): PROG_LOADER_CHECKSUM_EN
//                When defined, one extra byte follows the payload. It must
//                equal the XOR of all payload bytes, otherwise the loader
//                enters the error state and keeps the core in reset.
//
//  Ports
//    clk         in   1           system clock, rising edge
//    rst         in   1           asynchronous, active-low reset
//    byte_valid  in   1           upstream byte present
//    byte_data   in   8           upstream byte
//    byte_ready  out  1           loader accepts byte (transfer = valid && ready)
//    reload      in   1           1-cycle pulse: abort/restart load
//    imem_we     out  1           instruction-memory write strobe (1-cycle pulse)
//    imem_addr   out  ADDR_WIDTH  word-aligned byte address
//    imem_wdata  out  DATA_WIDTH  assembled little-endian word
//    cpu_rst     out  1           active-high reset to the core
//    load_done   out  1           image loaded, core running
//    error       out  1           oversize image or checksum mismatch (sticky)
//
//  Revision    : 1.0  initial release
// ============================================================================
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  error
);

  // Word counters need one bit more than the word address so that a count
  // of exactly DEPTH words is representable.
  localparam int          c_WIDX_W = ADDR_WIDTH - 1;
  localparam logic [31:0] c_DEPTH  = 32'd1 << (ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CHK  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // State entered once the payload (or an empty header) is complete.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t c_PAYLOAD_END = S_CHK;
`else
  localparam state_t c_PAYLOAD_END = S_RUN;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic                w_xfer;
  logic                w_word_done;
  logic [31:0]         w_len;
  logic [1:0]          r_byte_idx;
  logic [23:0]         r_len;
  logic [23:0]         r_word_buf;
  logic [c_WIDX_W-1:0] r_word_idx;
  logic [c_WIDX_W-1:0] r_words_total;
  logic [c_WIDX_W-1:0] w_word_idx_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          r_xor;
`endif

  // byte_ready is a registered copy of "next state accepts bytes", so it is
  // a valid qualifier for the transfer in the current cycle.
  assign w_xfer         = byte_valid && byte_ready;
  assign w_len          = {byte_data, r_len};
  assign w_word_idx_inc = r_word_idx + c_WIDX_W'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LEN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_word_done  = 1'b0;

    if (reload) begin
      w_state_next = S_LEN;
    end else begin
      case (r_state)
        S_LEN: begin
          if (w_xfer && (r_byte_idx == 2'd3)) begin
            // Oversize check happens before any write, so word_idx can
            // never wrap past the end of memory.
            if (w_len == 32'd0) begin
              w_state_next = c_PAYLOAD_END;
            end else if (w_len > c_DEPTH) begin
              w_state_next = S_ERR;
            end else begin
              w_state_next = S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_xfer && (r_byte_idx == 2'd3)) begin
            w_word_done = 1'b1;
            // Leave S_DATA together with the last write; cpu_rst follows
            // the state one edge later, after the final word is in memory.
            if (w_word_idx_inc == r_words_total) begin
              w_state_next = c_PAYLOAD_END;
            end
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            w_state_next = (byte_data == r_xor) ? S_RUN : S_ERR;
          end
        end
`endif

        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_idx    <= 2'd0;
      r_len         <= '0;
      r_word_buf    <= '0;
      r_word_idx    <= '0;
      r_words_total <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor         <= 8'd0;
`endif
      byte_ready    <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      cpu_rst       <= 1'b1;
      load_done     <= 1'b0;
      error         <= 1'b0;
    end else if (reload) begin
      // Any byte transferring this cycle and any partial word are dropped.
      r_byte_idx    <= 2'd0;
      r_len         <= '0;
      r_word_buf    <= '0;
      r_word_idx    <= '0;
      r_words_total <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor         <= 8'd0;
`endif
      byte_ready    <= 1'b1;
      imem_we       <= 1'b0;
      cpu_rst       <= 1'b1;
      load_done     <= 1'b0;
      error         <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      byte_ready <= (w_state_next == S_LEN)  ||
                    (w_state_next == S_DATA) ||
                    (w_state_next == S_CHK);
      // Status follows the current state, i.e. one edge behind the state
      // change, so the last imem write lands before the core is released.
      cpu_rst    <= (r_state != S_RUN);
      load_done  <= (r_state == S_RUN);
      error      <= (r_state == S_ERR);

      case (r_state)
        S_LEN: begin
          if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0:    r_len[7:0]    <= byte_data;
              2'd1:    r_len[15:8]   <= byte_data;
              2'd2:    r_len[23:16]  <= byte_data;
              default: r_words_total <= w_len[c_WIDX_W-1:0];
            endcase
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ byte_data;
`endif
            case (r_byte_idx)
              2'd0:    r_word_buf[7:0]   <= byte_data;
              2'd1:    r_word_buf[15:8]  <= byte_data;
              2'd2:    r_word_buf[23:16] <= byte_data;
              default: r_word_buf        <= r_word_buf;
            endcase
            if (w_word_done) begin
              imem_we    <= 1'b1;
              imem_wdata <= DATA_WIDTH'({byte_data, r_word_buf});
              imem_addr  <= {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
              r_word_idx <= w_word_idx_inc;
            end
          end
        end

        default: begin
          r_byte_idx <= r_byte_idx;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
